decode_stage: RTL and testbench

Registered, parametrised RV32I/RV64I decode stage for corev2. It sits between fetch and issue. It accepts one instruction per cycle over a valid/ready handshake and decodes it into register indices, valid bits, a sign-extended immediate, an operation class and an illegal-instruction flag. Results are held in a 2-entry output buffer so that issue back-pressure never creates a combinational path back to fetch.

---
 rtl/decode_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage with a 2-entry registered output buffer between fetch and issue.
// Optional macro DECODE_M_EXT_EN enables decoding of the M extension (class MUL).
module decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [4:0]      out_rd_o,
  output logic [4:0]      out_rs1_o,
  output logic [4:0]      out_rs2_o,
  output logic            out_rd_v_o,
  output logic            out_rs1_v_o,
  output logic            out_rs2_v_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [2:0]      out_class_o,
  output logic [2:0]      out_funct3_o,
  output logic            out_alt_o,
  output logic            out_word_o,
  output logic            out_illegal_o
);

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_BRANCH = 3'd1,
    CLS_JUMP   = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_UPPER  = 3'd5,
    CLS_MUL    = 3'd6
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_v;
    logic            rs1_v;
    logic            rs2_v;
    logic [XLEN-1:0] imm;
    op_class_e       cls;
    logic [2:0]      funct3;
    logic            alt;
    logic            word;
    logic            illegal;
  } entry_t;

`ifdef DECODE_M_EXT_EN
  localparam logic MExtEn = 1'b1;
`else
  localparam logic MExtEn = 1'b0;
`endif

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  entry_t     dec;
  imm_sel_e   imm_sel;
  logic       legal;
  logic       rv64_op;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    dec       = '0;
    imm_sel   = IMM_NONE;
    legal     = 1'b1;
    rv64_op   = 1'b0;
    dec.pc     = pc_i;
    dec.rd     = instr_i[11:7];
    dec.rs1    = instr_i[19:15];
    dec.rs2    = instr_i[24:20];
    dec.funct3 = funct3;
    dec.alt    = instr_i[30];
    dec.cls    = CLS_ALU;

    case (opcode)
      7'b0110011, 7'b0111011: begin
        rv64_op   = (opcode == 7'b0111011);
        dec.rd_v  = 1'b1;
        dec.rs1_v = 1'b1;
        dec.rs2_v = 1'b1;
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.cls = CLS_ALU;
        end else if (funct7 == 7'b0000001 && MExtEn) begin
          dec.cls = CLS_MUL;
        end else begin
          legal = 1'b0;
        end
      end
      7'b0010011, 7'b0011011: begin
        rv64_op   = (opcode == 7'b0011011);
        dec.rd_v  = 1'b1;
        dec.rs1_v = 1'b1;
        imm_sel   = IMM_I;
        // RV32 shamt is 5 bits; bit 25 set is a reserved encoding
        if (XLEN == 32 && funct3[1:0] == 2'b01 && instr_i[25]) legal = 1'b0;
      end
      7'b0000011: begin
        dec.cls   = CLS_LOAD;
        dec.rd_v  = 1'b1;
        dec.rs1_v = 1'b1;
        imm_sel   = IMM_I;
      end
      7'b0100011: begin
        dec.cls   = CLS_STORE;
        dec.rs1_v = 1'b1;
        dec.rs2_v = 1'b1;
        imm_sel   = IMM_S;
      end
      7'b1100011: begin
        dec.cls   = CLS_BRANCH;
        dec.rs1_v = 1'b1;
        dec.rs2_v = 1'b1;
        imm_sel   = IMM_B;
      end
      7'b0110111, 7'b0010111: begin
        dec.cls  = CLS_UPPER;
        dec.rd_v = 1'b1;
        imm_sel  = IMM_U;
      end
      7'b1101111: begin
        dec.cls  = CLS_JUMP;
        dec.rd_v = 1'b1;
        imm_sel  = IMM_J;
      end
      7'b1100111: begin
        dec.cls   = CLS_JUMP;
        dec.rd_v  = 1'b1;
        dec.rs1_v = 1'b1;
        imm_sel   = IMM_I;
        if (funct3 != 3'b000) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase

    case (imm_sel)
      IMM_I:   dec.imm = XLEN'($signed(instr_i[31:20]));
      IMM_S:   dec.imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      IMM_B:   dec.imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                        instr_i[11:8], 1'b0}));
      IMM_U:   dec.imm = XLEN'($signed({instr_i[31:12], 12'h000}));
      IMM_J:   dec.imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                        instr_i[30:21], 1'b0}));
      default: dec.imm = '0;
    endcase

    if (instr_i[1:0] != 2'b11 || (rv64_op && XLEN != 64)) legal = 1'b0;
    dec.word = rv64_op & legal;
    dec.rd_v = dec.rd_v & (instr_i[11:7] != 5'd0);

    if (!legal) begin
      dec.rd_v    = 1'b0;
      dec.rs1_v   = 1'b0;
      dec.rs2_v   = 1'b0;
      dec.cls     = CLS_ALU;
      dec.imm     = '0;
      dec.illegal = 1'b1;
    end
  end

  entry_t     mem_q [2];
  logic       head_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       in_ready_q;
  logic       push;
  logic       pop;
  logic       tail;
  entry_t     head;

  assign out_valid_o = (count_q != 2'd0);
  assign in_ready_o  = in_ready_q;
  assign push        = in_valid_i & in_ready_q & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign tail        = head_q ^ count_q[0];

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Ready is registered from the next count, so a pop at full never frees a same-cycle push
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      head_q     <= 1'b0;
      in_ready_q <= 1'b1;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else if (flush_i) begin
      count_q    <= '0;
      head_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) mem_q[tail] <= dec;
      if (pop) head_q <= ~head_q;
      count_q    <= count_d;
      in_ready_q <= (count_d < 2'd2);
    end
  end

  assign head          = mem_q[head_q];
  assign out_pc_o      = head.pc;
  assign out_rd_o      = head.rd;
  assign out_rs1_o     = head.rs1;
  assign out_rs2_o     = head.rs2;
  assign out_rd_v_o    = head.rd_v;
  assign out_rs1_v_o   = head.rs1_v;
  assign out_rs2_v_o   = head.rs2_v;
  assign out_imm_o     = head.imm;
  assign out_class_o   = head.cls;
  assign out_funct3_o  = head.funct3;
  assign out_alt_o     = head.alt;
  assign out_word_o    = head.word;
  assign out_illegal_o = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are checked against a queue-based reference model and a vector table.
module tb_decode_stage;

`ifdef DECODE_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, ready;
    logic [63:0] pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic        rdv, rs1v, rs2v, alt, word, ill;
    logic [2:0]  cls, f3;
  } obs_t;

  typedef struct {
    logic        ill, rdv, rs1v, rs2v, word;
    logic [2:0]  cls;
    logic [63:0] imm;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        ill32, ill64;
    logic [2:0]  cls;
    logic [63:0] imm;
    logic        rdv, rs1v, rs2v, word64;
  } vec_t;

  logic        r32, v32, rdv32, rs1v32, rs2v32, alt32, w32, il32;
  logic [31:0] pc32, imm32;
  logic [4:0]  rd32, rs132, rs232;
  logic [2:0]  cl32, f332;
  logic        r64, v64, rdv64, rs1v64, rs2v64, alt64, w64, il64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rd64, rs164, rs264;
  logic [2:0]  cl64, f364;

  decode_stage #(.XLEN(32)) u32 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r32),
    .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(v32), .out_ready_i(out_ready),
    .out_pc_o(pc32), .out_rd_o(rd32), .out_rs1_o(rs132), .out_rs2_o(rs232),
    .out_rd_v_o(rdv32), .out_rs1_v_o(rs1v32), .out_rs2_v_o(rs2v32), .out_imm_o(imm32),
    .out_class_o(cl32), .out_funct3_o(f332), .out_alt_o(alt32), .out_word_o(w32),
    .out_illegal_o(il32));

  decode_stage #(.XLEN(64)) u64 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r64),
    .instr_i(instr), .pc_i(pc), .out_valid_o(v64), .out_ready_i(out_ready),
    .out_pc_o(pc64), .out_rd_o(rd64), .out_rs1_o(rs164), .out_rs2_o(rs264),
    .out_rd_v_o(rdv64), .out_rs1_v_o(rs1v64), .out_rs2_v_o(rs2v64), .out_imm_o(imm64),
    .out_class_o(cl64), .out_funct3_o(f364), .out_alt_o(alt64), .out_word_o(w64),
    .out_illegal_o(il64));

  obs_t o32, o64;
  always_comb begin
    o32 = '{valid: v32, ready: r32, pc: {32'h0, pc32}, imm: {32'h0, imm32}, rd: rd32,
            rs1: rs132, rs2: rs232, rdv: rdv32, rs1v: rs1v32, rs2v: rs2v32, alt: alt32,
            word: w32, ill: il32, cls: cl32, f3: f332};
    o64 = '{valid: v64, ready: r64, pc: pc64, imm: imm64, rd: rd64, rs1: rs164, rs2: rs264,
            rdv: rdv64, rs1v: rs1v64, rs2v: rs2v64, alt: alt64, word: w64, ill: il64,
            cls: cl64, f3: f364};
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t exp_q[$];
  logic exp_ready = 1'b1;
  logic [6:0] ops [0:10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h67, 7'h1B, 7'h3B};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode written directly from the opcode rules
  function automatic dec_t ref_dec(logic [31:0] ins, int xlen);
    dec_t        d;
    logic [6:0]  op = ins[6:0];
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [11:0] fi = ins[31:20];
    logic [11:0] fs = {ins[31:25], ins[11:7]};
    logic [12:0] fb = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [31:0] fu = {ins[31:12], 12'h000};
    logic [20:0] fj = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    bit ok = 1, rv64 = 0;
    d = '{default: '0};
    case (op)
      7'h33, 7'h3B: begin
        rv64 = (op == 7'h3B); d.rdv = 1; d.rs1v = 1; d.rs2v = 1;
        if (f7 == 7'h00 || f7 == 7'h20) d.cls = 0;
        else if (f7 == 7'h01 && M_EN) d.cls = 6;
        else ok = 0;
      end
      7'h13, 7'h1B: begin
        rv64 = (op == 7'h1B); d.rdv = 1; d.rs1v = 1; d.imm = 64'($signed(fi));
        if (xlen == 32 && (f3 == 3'd1 || f3 == 3'd5) && ins[25]) ok = 0;
      end
      7'h03: begin d.cls = 3; d.rdv = 1; d.rs1v = 1; d.imm = 64'($signed(fi)); end
      7'h23: begin d.cls = 4; d.rs1v = 1; d.rs2v = 1; d.imm = 64'($signed(fs)); end
      7'h63: begin d.cls = 1; d.rs1v = 1; d.rs2v = 1; d.imm = 64'($signed(fb)); end
      7'h37, 7'h17: begin d.cls = 5; d.rdv = 1; d.imm = 64'($signed(fu)); end
      7'h6F: begin d.cls = 2; d.rdv = 1; d.imm = 64'($signed(fj)); end
      7'h67: begin
        d.cls = 2; d.rdv = 1; d.rs1v = 1; d.imm = 64'($signed(fi));
        if (f3 != 3'd0) ok = 0;
      end
      default: ok = 0;
    endcase
    if (ins[1:0] != 2'b11 || (rv64 && xlen == 32)) ok = 0;
    if (!ok) begin
      d = '{default: '0};
      d.ill = 1;
    end else begin
      d.word = rv64;
      if (ins[11:7] == 5'd0) d.rdv = 0;
    end
    return d;
  endfunction

  function automatic dec_t tbl_exp(vec_t v, int xlen);
    dec_t d;
    d = '{default: '0};
    if ((xlen == 32) ? v.ill32 : v.ill64) begin
      d.ill = 1;
    end else begin
      d.cls = v.cls; d.imm = v.imm; d.rdv = v.rdv; d.rs1v = v.rs1v; d.rs2v = v.rs2v;
      d.word = (xlen == 64) ? v.word64 : 1'b0;
    end
    return d;
  endfunction

  task automatic cmp_head(string t, obs_t o, logic [31:0] ins, logic [63:0] p,
                          dec_t d, int xlen);
    logic [63:0] m = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    chk({t, "_valid"}, o.valid, 1);
    chk({t, "_pc"}, o.pc, p & m);
    chk({t, "_rd"}, o.rd, ins[11:7]);
    chk({t, "_rs1"}, o.rs1, ins[19:15]);
    chk({t, "_rs2"}, o.rs2, ins[24:20]);
    chk({t, "_rdv"}, o.rdv, d.rdv);
    chk({t, "_rs1v"}, o.rs1v, d.rs1v);
    chk({t, "_rs2v"}, o.rs2v, d.rs2v);
    chk({t, "_imm"}, o.imm, d.imm & m);
    chk({t, "_class"}, o.cls, d.cls);
    chk({t, "_funct3"}, o.f3, ins[14:12]);
    chk({t, "_alt"}, o.alt, ins[30]);
    chk({t, "_word"}, o.word, d.word);
    chk({t, "_illegal"}, o.ill, d.ill);
  endtask

  task automatic check_outputs();
    chk("ready32", o32.ready, exp_ready);
    chk("ready64", o64.ready, exp_ready);
    if (exp_q.size() == 0) begin
      chk("valid32", o32.valid, 0);
      chk("valid64", o64.valid, 0);
    end else begin
      cmp_head("m32", o32, exp_q[0].instr, exp_q[0].pc, ref_dec(exp_q[0].instr, 32), 32);
      cmp_head("m64", o64, exp_q[0].instr, exp_q[0].pc, ref_dec(exp_q[0].instr, 64), 64);
    end
  endtask

  // One clock: model transition from the pre-edge inputs, then check #1 after the edge
  task automatic cycle();
    bit   acc, pp;
    ent_t e;
    acc = in_valid && exp_ready && !flush && !reset;
    pp  = (exp_q.size() > 0) && out_ready && !flush && !reset;
    e   = '{instr: instr, pc: pc};
    @(posedge clk);
    #1;
    if (reset || flush) begin
      exp_q.delete();
      exp_ready = 1'b1;
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
      exp_ready = (exp_q.size() < 2);
    end
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    if ($urandom_range(9) != 0) w[6:0] = ops[$urandom_range(10)];
    case ($urandom_range(3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(1) != 0) w[14:12] = 3'd0;
    return w;
  endfunction

  vec_t        tbl[$];
  logic [63:0] got[$];
  int          idx;

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; instr = '0; pc = '0;
    cycle();
    cycle();
    reset = 0;
    chk("rst_pc32", o32.pc, 0);
    chk("rst_pc64", o64.pc, 0);
    chk("rst_imm64", o64.imm, 0);
    chk("rst_class64", o64.cls, 0);
    chk("rst_ill32", o32.ill, 0);

    tbl.push_back('{32'hFFF00093, 64'h100, 0, 0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0});
    tbl.push_back('{32'hFE208EE3, 64'h104, 0, 0, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 0});
`ifdef DECODE_M_EXT_EN
    tbl.push_back('{32'h022081B3, 64'h108, 0, 0, 3'd6, 64'h0, 1, 1, 1, 0});
`else
    tbl.push_back('{32'h022081B3, 64'h108, 1, 1, 3'd0, 64'h0, 0, 0, 0, 0});
`endif
    tbl.push_back('{32'h0012829B, 64'h8000_0000_0000_010C, 1, 0, 3'd0, 64'h1, 1, 1, 0, 1});
    tbl.push_back('{32'h80000537, 64'h110, 0, 0, 3'd5, 64'hFFFF_FFFF_8000_0000, 1, 0, 0, 0});
    tbl.push_back('{32'h0000006F, 64'h114, 0, 0, 3'd2, 64'h0, 0, 0, 0, 0});
    tbl.push_back('{32'hFE20AFA3, 64'h118, 0, 0, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 0});
    tbl.push_back('{32'h000090E7, 64'h11C, 1, 1, 3'd0, 64'h0, 0, 0, 0, 0});
    tbl.push_back('{32'h02009093, 64'h120, 1, 0, 3'd0, 64'h20, 1, 1, 0, 0});
    tbl.push_back('{32'h00000001, 64'h124, 1, 1, 3'd0, 64'h0, 0, 0, 0, 0});
    tbl.push_back('{32'h20208033, 64'h128, 1, 1, 3'd0, 64'h0, 0, 0, 0, 0});

    out_ready = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = 1; instr = tbl[i].instr; pc = tbl[i].pc;
      cycle();
      cmp_head($sformatf("vec%0d_32", i), o32, tbl[i].instr, tbl[i].pc, tbl_exp(tbl[i], 32), 32);
      cmp_head($sformatf("vec%0d_64", i), o64, tbl[i].instr, tbl[i].pc, tbl_exp(tbl[i], 64), 64);
      in_valid = 0;
      cycle();
    end

    // Back-pressure: three offered, only two fit; then drain in order
    out_ready = 0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3); instr = 32'h00100093 + (idx << 20); pc = 64'h200 + 4 * idx;
      if (in_valid && o32.ready) begin
        cycle(); idx++;
      end else cycle();
    end
    chk("bp_accepted", 64'(idx), 2);
    chk("bp_full_ready", o32.ready, 0);
    out_ready = 1;
    for (int c = 0; c < 10 && (idx < 3 || o32.valid); c++) begin
      bit take;
      in_valid = (idx < 3); instr = 32'h00100093 + (idx << 20); pc = 64'h200 + 4 * idx;
      take = in_valid && o32.ready;
      if (o32.valid) got.push_back(o32.pc);
      cycle();
      if (take) idx++;
    end
    chk("bp_drained", 64'(got.size()), 3);
    for (int k = 0; k < got.size(); k++) chk($sformatf("bp_order%0d", k), got[k], 64'h200 + 4 * k);

    // Flush at full with a same-cycle offer
    out_ready = 0; in_valid = 1;
    for (int c = 0; c < 2; c++) begin
      instr = 32'h00500293; pc = 64'h300 + 4 * c;
      cycle();
    end
    instr = 32'h00700393; pc = 64'h3F0; flush = 1;
    cycle();
    flush = 0; in_valid = 0;
    chk("flush_valid", o32.valid, 0);
    chk("flush_ready", o32.ready, 1);
    out_ready = 1;
    cycle();
    cycle();
    chk("flush_nothing", o64.valid, 0);

    // Reset with an entry buffered and a same-cycle offer
    in_valid = 1; out_ready = 0; instr = 32'h00A00513; pc = 64'h400;
    cycle();
    reset = 1; pc = 64'h404;
    cycle();
    reset = 0; in_valid = 0;
    chk("midrst_valid", o32.valid, 0);
    chk("midrst_pc", o64.pc, 0);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(24) == 0);
      reset     = ($urandom_range(299) == 0);
      instr     = rand_instr();
      pc        = {$urandom, $urandom};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
